// File: rtl/sma_decoder.sv
// Inverse of the 4-tap moving-sum filter: rebuilds x[n] = s[n] - x[n-1] - x[n-2] - x[n-3]
// from an 18-bit running sum, with a range check that parks the block in ERROR until resync.
module sma_decoder (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    input  logic signed [17:0] s_sum,
    output logic               s_ready,
    output logic               m_valid,
    output logic signed [15:0] m_x,
    input  logic               m_ready,
    input  logic               resync,
    output logic               err,
    output logic [15:0]        count,
    output logic               dbg_state
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_ERROR = 1'b1
    } state_t;

    state_t             state_q;
    logic signed [15:0] h1_q;
    logic signed [15:0] h2_q;
    logic signed [15:0] h3_q;
    logic               m_valid_q;
    logic signed [15:0] m_x_q;
    logic               err_q;
    logic [15:0]        count_q;

    logic signed [19:0] sum_ext;
    logic signed [19:0] hist_sum;
    logic signed [19:0] diff;
    logic               in_range;
    logic               in_accept;
    logic               out_xfer;

    // Handshake: a beat moves on a rising edge only when valid && ready are both high in
    // that cycle; valid and payload are held stable until then, ready may change freely.
    // In RUN the single output register is refilled in the same cycle it drains.
    assign s_ready   = (state_q == ST_ERROR) ? 1'b1 : (!m_valid_q || m_ready);
    assign in_accept = s_valid && s_ready;
    assign out_xfer  = m_valid_q && m_ready;

    // Full 20-bit signed arithmetic so out-of-range results are never masked by wrap-around.
    assign sum_ext  = {{2{s_sum[17]}}, s_sum};
    assign hist_sum = {{4{h1_q[15]}}, h1_q} + {{4{h2_q[15]}}, h2_q} + {{4{h3_q[15]}}, h3_q};
    assign diff     = sum_ext - hist_sum;
    assign in_range = (diff >= -20'sd32768) && (diff <= 20'sd32767);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            h1_q      <= '0;
            h2_q      <= '0;
            h3_q      <= '0;
            m_valid_q <= 1'b0;
            m_x_q     <= '0;
            err_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            if (out_xfer) begin
                m_valid_q <= 1'b0;
            end

            if (resync) begin
                // A same-cycle input is swallowed; count survives the flush.
                state_q   <= ST_RUN;
                h1_q      <= '0;
                h2_q      <= '0;
                h3_q      <= '0;
                m_valid_q <= 1'b0;
                err_q     <= 1'b0;
            end else if (state_q == ST_RUN && in_accept) begin
                if (in_range) begin
                    m_x_q     <= diff[15:0];
                    m_valid_q <= 1'b1;
                    h1_q      <= diff[15:0];
                    h2_q      <= h1_q;
                    h3_q      <= h2_q;
                    count_q   <= count_q + 16'd1;
                end else begin
                    state_q <= ST_ERROR;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    assign m_valid   = m_valid_q;
    assign m_x       = m_x_q;
    assign err       = err_q;
    assign count     = count_q;
    assign dbg_state = (state_q == ST_ERROR);

endmodule

// File: tb/tb_sma_decoder.sv
// Randomised scoreboard bench for sma_decoder: a sum-level reference model predicts each
// reconstructed sample, and an independent monitor checks every output transfer in order.
module tb_sma_decoder;

    logic               clk = 1'b0;
    logic               rst;
    logic               s_valid;
    logic signed [17:0] s_sum;
    logic               s_ready;
    logic               m_valid;
    logic signed [15:0] m_x;
    logic               m_ready;
    logic               resync;
    logic               err;
    logic [15:0]        count;
    logic               dbg_state;

    always #5 clk = ~clk;

    sma_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_sum     (s_sum),
        .s_ready   (s_ready),
        .m_valid   (m_valid),
        .m_x       (m_x),
        .m_ready   (m_ready),
        .resync    (resync),
        .err       (err),
        .count     (count),
        .dbg_state (dbg_state)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];

    // Reference model: the last three reconstructed samples, newest first.
    int          mh[3];
    bit          mdl_err;
    int unsigned mdl_cnt;
    bit          rand_ready;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear(input bit clear_count);
        mh      = '{0, 0, 0};
        mdl_err = 1'b0;
        exp_q.delete();
        if (clear_count) mdl_cnt = 0;
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_err"}, err, mdl_err);
        chk({tag, "_state"}, dbg_state, mdl_err);
        chk({tag, "_count"}, count, mdl_cnt % 65536);
    endtask

    // Offer one sum; returns at posedge+1 after it is accepted (or after a timeout).
    task automatic send(input int sum);
        int  d;
        int  budget;
        bit  taken;
        s_valid = 1'b1;
        s_sum   = sum[17:0];
        budget  = 0;
        taken   = 1'b0;
        forever begin
            if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (mdl_err) chk("s_ready_in_error", s_ready, 1);
            if (s_ready) begin
                taken = 1'b1;
                break;
            end
            budget++;
            if (budget > 50) begin
                chk("accept_timeout", 0, 1);
                break;
            end
            @(posedge clk);
            #1;
        end
        if (taken && !mdl_err) begin
            d = sum - (mh[0] + mh[1] + mh[2]);
            if (d >= -32768 && d <= 32767) begin
                exp_q.push_back(d[15:0]);
                mh[2] = mh[1];
                mh[1] = mh[0];
                mh[0] = d;
                mdl_cnt++;
            end else begin
                mdl_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        check_status("send");
    endtask

    task automatic do_resync(input int sum);
        s_valid = 1'b1;
        s_sum   = sum[17:0];
        resync  = 1'b1;
        @(negedge clk);
        if (mdl_err) chk("s_ready_resync", s_ready, 1);
        @(posedge clk);
        #1;
        resync  = 1'b0;
        s_valid = 1'b0;
        model_clear(1'b0);
        chk("resync_m_valid", m_valid, 0);
        check_status("resync");
    endtask

    task automatic drain(input string tag);
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin : monitor
        logic               held;
        logic signed [15:0] held_x;
        logic [15:0]        e;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && m_valid) begin
                if (held) chk("hold_stable", m_x, held_x);
                if (m_ready) begin
                    held = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", m_x, 99999);
                    end else begin
                        e = exp_q.pop_front();
                        chk("m_x", m_x, $signed(e));
                    end
                end else begin
                    held   = 1'b1;
                    held_x = m_x;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin : stimulus
        int basic_sums[5];
        int fs_sums[5];
        int neg_sums[4];
        int r;
        int x;

        basic_sums = '{100, 300, 600, 1000, 1400};
        fs_sums    = '{32767, 65534, 98301, 131068, -131072};
        neg_sums   = '{-32768, -65536, -98304, -131072};

        s_valid    = 1'b0;
        s_sum      = '0;
        m_ready    = 1'b1;
        resync     = 1'b0;
        rand_ready = 1'b0;
        rst        = 1'b1;
        model_clear(1'b1);

        #2;
        chk("reset_s_ready", s_ready, 1);
        chk("reset_m_valid", m_valid, 0);
        chk("reset_m_x", m_x, 0);
        chk("reset_err", err, 0);
        chk("reset_count", count, 0);
        chk("reset_state", dbg_state, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic decode: expected 100..500
        foreach (basic_sums[i]) send(basic_sums[i]);
        drain("basic");
        chk("basic_count", count, 5);

        // Full-scale positive run ending in a range error
        do_resync(0);
        foreach (fs_sums[i]) send(fs_sums[i]);
        drain("fullscale");
        chk("fullscale_err", err, 1);

        // Full-scale negative run
        do_resync(0);
        foreach (neg_sums[i]) send(neg_sums[i]);
        drain("negative");

        // Back-pressure: 3-cycle stall with sample 20 pending
        do_resync(0);
        send(10);
        send(30);
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_sum   = 18'sd60;
        repeat (3) begin
            @(negedge clk);
            chk("stall_s_ready", s_ready, 0);
            chk("stall_m_valid", m_valid, 1);
            chk("stall_m_x", m_x, 20);
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        send(60);
        send(100);
        drain("stall");

        // Range error straight after reset
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear(1'b1);
        send(40000);
        chk("range_err", err, 1);
        chk("range_m_valid", m_valid, 0);
        chk("range_state", dbg_state, 1);
        send(123);
        send(-5);
        chk("range_no_output", m_valid, 0);

        // Resync with a coincident sum of 7, which must be dropped
        do_resync(7);
        send(5);
        send(15);
        drain("resync");

        // Asynchronous reset between edges with a sample pending
        m_ready = 1'b0;
        send(20);
        #1;
        rst = 1'b1;
        #1;
        chk("async_m_valid", m_valid, 0);
        chk("async_err", err, 0);
        chk("async_count", count, 0);
        chk("async_s_ready", s_ready, 1);
        model_clear(1'b1);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_ready = 1'b1;
        send(9);
        drain("async");

        // Randomised traffic: mostly legal encoder output, some arbitrary sums and resyncs
        rand_ready = 1'b1;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                do_resync(int'($urandom_range(0, 1000)));
            end else if (r < 6) begin
                send(int'($urandom_range(0, 262143)) - 131072);
            end else if (r < 12) begin
                m_ready = ($urandom_range(0, 1) != 0);
                @(posedge clk);
                #1;
            end else begin
                x = int'($urandom_range(0, 65535)) - 32768;
                send(x + mh[0] + mh[1] + mh[2]);
            end
        end
        rand_ready = 1'b0;
        drain("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
